// File: rtl/fpu_divsqrt_seq.sv
// Issue sequencer for the iterative FP divide/sqrt unit: accepts one operation at a time,
// pulses start/kill to the unit, buffers the result for write-back, and watches for a hung unit.
module fpu_divsqrt_seq #(
   parameter int unsigned MAX_CYCLES = 64,
   parameter int unsigned TAG_W      = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic             in_op_i,
   input  logic [31:0]      in_a_i,
   input  logic [31:0]      in_b_i,
   input  logic [2:0]       in_rm_i,
   input  logic [TAG_W-1:0] in_tag_i,
   input  logic             flush_i,
   output logic             unit_start_o,
   output logic             unit_op_o,
   output logic [31:0]      unit_a_o,
   output logic [31:0]      unit_b_o,
   output logic [2:0]       unit_rm_o,
   output logic             unit_kill_o,
   input  logic             unit_done_i,
   input  logic [31:0]      unit_result_i,
   input  logic [4:0]       unit_status_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [31:0]      out_result_o,
   output logic [4:0]       out_status_o,
   output logic [TAG_W-1:0] out_tag_o,
   output logic             busy_o,
   output logic             timeout_o
);

   localparam int unsigned CNT_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned STAT_W   = 5;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYCLES - 1);
   localparam logic [DATA_W-1:0] QNAN      = 32'h7FC0_0000;
   localparam logic [STAT_W-1:0] STAT_NV   = 5'b10000;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_WAIT  = 3'd2,
      S_KILL  = 3'd3,
      S_HOLD  = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             kill_to_hold_q;
   logic             timeout_q;

   logic accept_c;
   logic cnt_clr_c;
   logic cnt_inc_c;
   logic cap_done_c;
   logic expire_c;
   logic flush_kill_c;

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and unit/handshake strobes
   always_comb begin
      state_d      = state_q;
      in_ready_o   = 1'b0;
      unit_start_o = 1'b0;
      unit_kill_o  = 1'b0;
      out_valid_o  = 1'b0;
      accept_c     = 1'b0;
      cnt_clr_c    = 1'b0;
      cnt_inc_c    = 1'b0;
      cap_done_c   = 1'b0;
      expire_c     = 1'b0;
      flush_kill_c = 1'b0;

      case (state_q)
         S_IDLE: begin
            in_ready_o = !flush_i && !rst_i;
            accept_c   = in_valid_i && in_ready_o;
            if (accept_c) begin
               state_d = S_START;
            end
         end
         S_START: begin
            unit_start_o = !flush_i;
            cnt_clr_c    = 1'b1;
            state_d      = flush_i ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            // Flush beats a same-cycle completion; completion beats the watchdog
            if (flush_i) begin
               flush_kill_c = 1'b1;
               state_d      = S_KILL;
            end else if (unit_done_i) begin
               cap_done_c = 1'b1;
               state_d    = S_HOLD;
            end else if (cnt_q == CNT_LAST) begin
               expire_c = 1'b1;
               state_d  = S_KILL;
            end else begin
               cnt_inc_c = 1'b1;
            end
         end
         S_KILL: begin
            unit_kill_o = 1'b1;
            state_d     = (kill_to_hold_q && !flush_i) ? S_HOLD : S_IDLE;
         end
         S_HOLD: begin
            out_valid_o = !flush_i;
            in_ready_o  = out_ready_i && !flush_i && !rst_i;
            accept_c    = in_valid_i && in_ready_o;
            if (flush_i) begin
               state_d = S_IDLE;
            end else if (accept_c) begin
               state_d = S_START;
            end else if (out_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Operand latch, watchdog counter and result buffer
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         unit_op_o      <= 1'b0;
         unit_a_o       <= '0;
         unit_b_o       <= '0;
         unit_rm_o      <= '0;
         out_tag_o      <= '0;
         out_result_o   <= '0;
         out_status_o   <= '0;
         cnt_q          <= '0;
         kill_to_hold_q <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         if (accept_c) begin
            unit_op_o <= in_op_i;
            unit_a_o  <= in_a_i;
            unit_b_o  <= in_b_i;
            unit_rm_o <= in_rm_i;
            out_tag_o <= in_tag_i;
         end
         if (cnt_clr_c) begin
            cnt_q <= '0;
         end else if (cnt_inc_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if (cap_done_c) begin
            out_result_o <= unit_result_i;
            out_status_o <= unit_status_i;
         end else if (expire_c) begin
            out_result_o <= QNAN;
            out_status_o <= STAT_NV;
         end
         // KILL returns to HOLD only when it was entered through the watchdog
         if (expire_c) begin
            kill_to_hold_q <= 1'b1;
         end else if (flush_kill_c || cnt_clr_c) begin
            kill_to_hold_q <= 1'b0;
         end
         if (expire_c) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign busy_o    = (state_q != S_IDLE);
   assign timeout_o = timeout_q || (expire_c && !rst_i);

   // Protocol invariants of the unit and write-back interfaces
   a_start_kill_excl : assert property (@(posedge clk_i) disable iff (rst_i)
      !(unit_start_o && unit_kill_o));
   a_start_no_valid  : assert property (@(posedge clk_i) disable iff (rst_i)
      !(unit_start_o && out_valid_o));
   a_hold_stable     : assert property (@(posedge clk_i) disable iff (rst_i)
      (out_valid_o && !out_ready_i) |=> $stable({out_result_o, out_status_o, out_tag_o}));

endmodule

// File: tb/tb_fpu_divsqrt_seq.sv
// Self-checking bench for fpu_divsqrt_seq: directed scenarios plus randomized operations
// checked against a cycle-count model derived from the handshake timing rules.
module tb_fpu_divsqrt_seq;

   localparam int unsigned TAG_W  = 5;
   localparam int unsigned MAX_WD = 8;
   localparam logic [31:0] QNAN   = 32'h7FC00000;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic in_valid, in_op, flush, unit_done, out_ready;
   logic [31:0] in_a, in_b, unit_result;
   logic [2:0]  in_rm;
   logic [TAG_W-1:0] in_tag;
   logic [4:0]  unit_status;

   logic in_ready, unit_start, unit_op, unit_kill, out_valid, busy, timeout;
   logic [31:0] unit_a, unit_b, out_result;
   logic [2:0]  unit_rm;
   logic [4:0]  out_status;
   logic [TAG_W-1:0] out_tag;

   logic wd_in_ready, wd_start, wd_op, wd_kill, wd_valid, wd_busy, wd_timeout;
   logic [31:0] wd_a, wd_b, wd_result;
   logic [2:0]  wd_rm;
   logic [4:0]  wd_status;
   logic [TAG_W-1:0] wd_tag;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   fpu_divsqrt_seq #(.MAX_CYCLES(64), .TAG_W(TAG_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_op_i(in_op), .in_a_i(in_a), .in_b_i(in_b), .in_rm_i(in_rm), .in_tag_i(in_tag),
      .flush_i(flush), .unit_start_o(unit_start), .unit_op_o(unit_op), .unit_a_o(unit_a),
      .unit_b_o(unit_b), .unit_rm_o(unit_rm), .unit_kill_o(unit_kill), .unit_done_i(unit_done),
      .unit_result_i(unit_result), .unit_status_i(unit_status), .out_valid_o(out_valid),
      .out_ready_i(out_ready), .out_result_o(out_result), .out_status_o(out_status),
      .out_tag_o(out_tag), .busy_o(busy), .timeout_o(timeout));

   fpu_divsqrt_seq #(.MAX_CYCLES(MAX_WD), .TAG_W(TAG_W)) dut_wd (
      .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid), .in_ready_o(wd_in_ready),
      .in_op_i(in_op), .in_a_i(in_a), .in_b_i(in_b), .in_rm_i(in_rm), .in_tag_i(in_tag),
      .flush_i(flush), .unit_start_o(wd_start), .unit_op_o(wd_op), .unit_a_o(wd_a),
      .unit_b_o(wd_b), .unit_rm_o(wd_rm), .unit_kill_o(wd_kill), .unit_done_i(unit_done),
      .unit_result_i(unit_result), .unit_status_i(unit_status), .out_valid_o(wd_valid),
      .out_ready_i(out_ready), .out_result_o(wd_result), .out_status_o(wd_status),
      .out_tag_o(wd_tag), .busy_o(wd_busy), .timeout_o(wd_timeout));

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; flush = 1'b0; unit_done = 1'b0; out_ready = 1'b0;
      unit_result = '0; unit_status = '0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      idle_inputs();
      cyc();
      cyc();
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      idle_inputs();
      in_op = 1'b0; in_a = '0; in_b = '0; in_rm = '0; in_tag = '0;
      cyc();
      cyc();
      #2;
      n_checks++;
      if ({in_ready, unit_start, unit_kill, out_valid, busy, timeout, unit_op} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 0", {in_ready, unit_start, unit_kill, out_valid, busy, timeout, unit_op});
      end
      n_checks++;
      if ({unit_a, unit_b, unit_rm, out_result, out_status, out_tag} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got %h expected 0", {unit_a, unit_b, unit_rm, out_result, out_status, out_tag});
      end
      rst_i = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_idle: in_ready=%b busy=%b expected 1/0", in_ready, busy);
      end
      cyc();
   endtask

   task automatic test_divide();
      in_valid = 1'b1; in_op = 1'b0; in_a = 32'h40400000; in_b = 32'h40000000; in_rm = 3'd0; in_tag = 5'd3;
      #2;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL div_accept: in_ready=%b expected 1", in_ready); end
      cyc();
      in_valid = 1'b0; in_a = 32'h12345678; in_b = 32'h9ABCDEF0;
      for (int c = 1; c <= 14; c++) begin
         unit_done   = (c == 11);
         unit_result = (c == 11) ? 32'h3FC00000 : 32'hDEADBEEF;
         unit_status = 5'd0;
         out_ready   = (c == 13);
         #2;
         n_checks++;
         if (unit_start !== (c == 1)) begin n_fail++; $display("FAIL div_start c=%0d: got %b expected %b", c, unit_start, (c == 1)); end
         n_checks++;
         if (out_valid !== (c >= 12 && c <= 13)) begin n_fail++; $display("FAIL div_valid c=%0d: got %b expected %b", c, out_valid, (c >= 12 && c <= 13)); end
         n_checks++;
         if (busy !== (c <= 13)) begin n_fail++; $display("FAIL div_busy c=%0d: got %b expected %b", c, busy, (c <= 13)); end
         if (c == 1) begin
            n_checks++;
            if ({unit_op, unit_a, unit_b} !== {1'b0, 32'h40400000, 32'h40000000}) begin
               n_fail++; $display("FAIL div_operands: got %h expected %h", {unit_op, unit_a, unit_b}, {1'b0, 32'h40400000, 32'h40000000});
            end
         end
         if (c == 12) begin
            n_checks++;
            if ({out_result, out_status, out_tag} !== {32'h3FC00000, 5'd0, 5'd3}) begin
               n_fail++; $display("FAIL div_result: got %h expected %h", {out_result, out_status, out_tag}, {32'h3FC00000, 5'd0, 5'd3});
            end
         end
         cyc();
      end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1; in_op = 1'b0; in_a = 32'h40400000; in_b = 32'h40000000; in_rm = 3'd1; in_tag = 5'd1;
      cyc();
      in_valid = 1'b0;
      cyc();
      cyc();
      unit_done = 1'b1; unit_result = 32'h3FC00000; unit_status = 5'd0;
      cyc();
      unit_done = 1'b0;
      out_ready = 1'b1; in_valid = 1'b1; in_op = 1'b1; in_a = 32'h41800000; in_b = 32'h0; in_tag = 5'd2;
      #2;
      n_checks++;
      if ({out_valid, in_ready} !== 2'b11) begin n_fail++; $display("FAIL b2b_retire_accept: got %b expected 11", {out_valid, in_ready}); end
      n_checks++;
      if ({out_result, out_tag} !== {32'h3FC00000, 5'd1}) begin n_fail++; $display("FAIL b2b_first_result: got %h expected %h", {out_result, out_tag}, {32'h3FC00000, 5'd1}); end
      cyc();
      in_valid = 1'b0; out_ready = 1'b0;
      #2;
      n_checks++;
      if ({unit_start, unit_op, out_valid} !== 3'b110 || unit_a !== 32'h41800000) begin
         n_fail++; $display("FAIL b2b_start: start/op/valid=%b a=%h expected 110 41800000", {unit_start, unit_op, out_valid}, unit_a);
      end
      cyc();
      unit_done = 1'b1; unit_result = 32'h40800000;
      cyc();
      unit_done = 1'b0;
      #2;
      n_checks++;
      if ({out_valid, out_result, out_tag} !== {1'b1, 32'h40800000, 5'd2}) begin
         n_fail++; $display("FAIL b2b_second_result: got %h expected %h", {out_valid, out_result, out_tag}, {1'b1, 32'h40800000, 5'd2});
      end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      #2;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: busy=%b expected 0", busy); end
   endtask

   task automatic test_random(input int n);
      logic op;
      logic [31:0] a, b, res;
      logic [2:0] rm;
      logic [4:0] st;
      logic [TAG_W-1:0] tag;
      int k, bp, vc;
      for (int i = 0; i < n; i++) begin
         op = 1'($urandom); a = $urandom; b = $urandom; res = $urandom;
         rm = 3'($urandom_range(0, 4)); st = 5'($urandom); tag = TAG_W'($urandom);
         k = $urandom_range(1, 20); bp = $urandom_range(0, 3);
         vc = 2 + k;
         in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rm = rm; in_tag = tag;
         #2;
         n_checks++;
         if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_accept op%0d: in_ready=%b expected 1", i, in_ready); end
         cyc();
         in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
         for (int c = 1; c <= vc + bp; c++) begin
            unit_done   = (c == 1 + k) || ((c == 1 || c >= vc) && $urandom_range(0, 1) == 1);
            unit_result = (c == 1 + k) ? res : $urandom;
            unit_status = (c == 1 + k) ? st : 5'($urandom);
            out_ready   = (c == vc + bp);
            in_valid    = (c < vc) && ($urandom_range(0, 1) == 1);
            #2;
            n_checks++;
            if (unit_start !== (c == 1)) begin n_fail++; $display("FAIL rnd_start op%0d c=%0d: got %b expected %b", i, c, unit_start, (c == 1)); end
            n_checks++;
            if (out_valid !== (c >= vc)) begin n_fail++; $display("FAIL rnd_valid op%0d c=%0d: got %b expected %b", i, c, out_valid, (c >= vc)); end
            n_checks++;
            if (in_ready !== (c == vc + bp)) begin n_fail++; $display("FAIL rnd_ready op%0d c=%0d: got %b expected %b", i, c, in_ready, (c == vc + bp)); end
            n_checks++;
            if ({busy, unit_kill} !== 2'b10) begin n_fail++; $display("FAIL rnd_busy_kill op%0d c=%0d: got %b expected 10", i, c, {busy, unit_kill}); end
            if (c == 1) begin
               n_checks++;
               if ({unit_op, unit_a, unit_b, unit_rm} !== {op, a, b, rm}) begin
                  n_fail++; $display("FAIL rnd_operands op%0d: got %h expected %h", i, {unit_op, unit_a, unit_b, unit_rm}, {op, a, b, rm});
               end
            end
            if (c >= vc) begin
               n_checks++;
               if ({out_result, out_status, out_tag} !== {res, st, tag}) begin
                  n_fail++; $display("FAIL rnd_result op%0d c=%0d: got %h expected %h", i, c, {out_result, out_status, out_tag}, {res, st, tag});
               end
            end
            cyc();
         end
         idle_inputs();
         #2;
         n_checks++;
         if ({busy, out_valid} !== 2'b00) begin n_fail++; $display("FAIL rnd_retire op%0d: busy/valid=%b expected 00", i, {busy, out_valid}); end
      end
   endtask

   task automatic test_flush_wait();
      in_valid = 1'b1; in_op = 1'b0; in_a = $urandom; in_b = $urandom; in_tag = 5'd7;
      cyc();
      in_valid = 1'b0;
      cyc();
      flush = 1'b1; unit_done = 1'b1; unit_result = 32'hCAFEF00D;
      #2;
      n_checks++;
      if ({out_valid, unit_kill} !== 2'b00) begin n_fail++; $display("FAIL fw_flush_cycle: valid/kill=%b expected 00", {out_valid, unit_kill}); end
      cyc();
      flush = 1'b0; unit_done = 1'b0;
      #2;
      n_checks++;
      if ({unit_kill, busy, out_valid, unit_start} !== 4'b1100) begin
         n_fail++; $display("FAIL fw_kill: kill/busy/valid/start=%b expected 1100", {unit_kill, busy, out_valid, unit_start});
      end
      cyc();
      #2;
      n_checks++;
      if ({unit_kill, busy, out_valid, in_ready} !== 4'b0001) begin
         n_fail++; $display("FAIL fw_idle: kill/busy/valid/ready=%b expected 0001", {unit_kill, busy, out_valid, in_ready});
      end
      cyc();
      #2;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fw_no_late_result: valid=%b expected 0", out_valid); end
   endtask

   task automatic test_flush_start();
      in_valid = 1'b1; flush = 1'b1; in_op = 1'b1; in_a = $urandom;
      #2;
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fs_block_accept: in_ready=%b expected 0", in_ready); end
      cyc();
      #2;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL fs_not_accepted: busy=%b expected 0", busy); end
      flush = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fs_ready: in_ready=%b expected 1", in_ready); end
      cyc();
      in_valid = 1'b0; flush = 1'b1;
      #2;
      n_checks++;
      if ({unit_start, unit_kill, busy} !== 3'b001) begin n_fail++; $display("FAIL fs_suppress: start/kill/busy=%b expected 001", {unit_start, unit_kill, busy}); end
      cyc();
      flush = 1'b0;
      #2;
      n_checks++;
      if ({unit_start, unit_kill, busy} !== 3'b000) begin n_fail++; $display("FAIL fs_idle: start/kill/busy=%b expected 000", {unit_start, unit_kill, busy}); end
   endtask

   task automatic test_flush_hold();
      in_valid = 1'b1; in_op = 1'b0; in_a = $urandom; in_b = $urandom;
      cyc();
      in_valid = 1'b0;
      cyc();
      unit_done = 1'b1; unit_result = 32'h3F800000;
      cyc();
      unit_done = 1'b0; flush = 1'b1; out_ready = 1'b1;
      #2;
      n_checks++;
      if ({out_valid, in_ready, busy} !== 3'b001) begin n_fail++; $display("FAIL fh_suppress: valid/ready/busy=%b expected 001", {out_valid, in_ready, busy}); end
      cyc();
      flush = 1'b0; out_ready = 1'b0;
      #2;
      n_checks++;
      if ({out_valid, busy, unit_kill} !== 3'b000) begin n_fail++; $display("FAIL fh_dropped: valid/busy/kill=%b expected 000", {out_valid, busy, unit_kill}); end
   endtask

   task automatic test_backpressure();
      logic [31:0] r1;
      logic [4:0] s1;
      r1 = $urandom; s1 = 5'($urandom);
      in_valid = 1'b1; in_op = 1'b0; in_a = $urandom; in_b = $urandom; in_tag = 5'd9;
      cyc();
      in_valid = 1'b0;
      cyc();
      unit_done = 1'b1; unit_result = r1; unit_status = s1;
      cyc();
      for (int c = 0; c < 5; c++) begin
         out_ready = 1'b0; in_valid = 1'b1; unit_done = 1'b1; unit_result = ~r1; unit_status = ~s1;
         #2;
         n_checks++;
         if ({out_valid, in_ready} !== 2'b10) begin n_fail++; $display("FAIL bp_handshake c=%0d: valid/ready=%b expected 10", c, {out_valid, in_ready}); end
         n_checks++;
         if ({out_result, out_status, out_tag} !== {r1, s1, 5'd9}) begin
            n_fail++; $display("FAIL bp_stable c=%0d: got %h expected %h", c, {out_result, out_status, out_tag}, {r1, s1, 5'd9});
         end
         cyc();
      end
      in_valid = 1'b0; unit_done = 1'b0; out_ready = 1'b1;
      cyc();
      out_ready = 1'b0; unit_done = 1'b1; unit_result = 32'hFFFFFFFF;
      #2;
      n_checks++;
      if ({busy, out_valid} !== 2'b00) begin n_fail++; $display("FAIL bp_retired: busy/valid=%b expected 00", {busy, out_valid}); end
      cyc();
      unit_done = 1'b0;
      #2;
      n_checks++;
      if ({busy, out_valid} !== 2'b00) begin n_fail++; $display("FAIL idle_spurious_done: busy/valid=%b expected 00", {busy, out_valid}); end
   endtask

   task automatic test_reset_midop();
      in_valid = 1'b1; in_op = 1'b1; in_a = $urandom;
      cyc();
      in_valid = 1'b0;
      cyc();
      rst_i = 1'b1;
      cyc();
      rst_i = 1'b0;
      #2;
      n_checks++;
      if ({busy, unit_kill, unit_start, out_valid} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_midop: busy/kill/start/valid=%b expected 0000", {busy, unit_kill, unit_start, out_valid});
      end
   endtask

   task automatic test_watchdog();
      logic op, to;
      logic [31:0] a, b, res;
      logic [2:0] rm;
      logic [4:0] st;
      logic [TAG_W-1:0] tag;
      int k, vc;
      for (int t = 0; t < 3; t++) begin
         k  = (t == 0) ? MAX_WD : ((t == 1) ? MAX_WD + 1 : 0);
         to = (k == 0) || (k > MAX_WD);
         vc = to ? 3 + MAX_WD : 2 + k;
         op = 1'($urandom); a = $urandom; b = $urandom; rm = 3'($urandom_range(0, 4));
         res = $urandom; st = 5'($urandom); tag = TAG_W'($urandom);
         do_reset();
         in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rm = rm; in_tag = tag;
         #2;
         n_checks++;
         if (wd_in_ready !== 1'b1) begin n_fail++; $display("FAIL wd_accept t=%0d: in_ready=%b expected 1", t, wd_in_ready); end
         cyc();
         in_valid = 1'b0;
         for (int c = 1; c <= vc + 2; c++) begin
            unit_done   = (k != 0) && (c == 1 + k);
            unit_result = res; unit_status = st;
            out_ready   = (c == vc + 2);
            #2;
            n_checks++;
            if (wd_timeout !== (to && c >= 1 + MAX_WD)) begin n_fail++; $display("FAIL wd_timeout t=%0d c=%0d: got %b expected %b", t, c, wd_timeout, (to && c >= 1 + MAX_WD)); end
            n_checks++;
            if (wd_kill !== (to && c == 2 + MAX_WD)) begin n_fail++; $display("FAIL wd_kill t=%0d c=%0d: got %b expected %b", t, c, wd_kill, (to && c == 2 + MAX_WD)); end
            n_checks++;
            if ({wd_start, wd_valid} !== {(c == 1), (c >= vc)}) begin n_fail++; $display("FAIL wd_start_valid t=%0d c=%0d: got %b expected %b", t, c, {wd_start, wd_valid}, {(c == 1), (c >= vc)}); end
            if (c == 1) begin
               n_checks++;
               if ({wd_op, wd_a, wd_b, wd_rm} !== {op, a, b, rm}) begin n_fail++; $display("FAIL wd_operands t=%0d: got %h expected %h", t, {wd_op, wd_a, wd_b, wd_rm}, {op, a, b, rm}); end
            end
            if (c >= vc) begin
               n_checks++;
               if ({wd_result, wd_status, wd_tag} !== (to ? {QNAN, 5'h10, tag} : {res, st, tag})) begin
                  n_fail++; $display("FAIL wd_result t=%0d c=%0d: got %h expected %h", t, c, {wd_result, wd_status, wd_tag}, (to ? {QNAN, 5'h10, tag} : {res, st, tag}));
               end
            end
            cyc();
         end
         idle_inputs();
         cyc();
         cyc();
         #2;
         n_checks++;
         if ({wd_busy, wd_timeout} !== {1'b0, to}) begin n_fail++; $display("FAIL wd_sticky t=%0d: busy/timeout=%b expected %b", t, {wd_busy, wd_timeout}, {1'b0, to}); end
      end
      do_reset();
      #2;
      n_checks++;
      if (wd_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_reset_clears: timeout=%b expected 0", wd_timeout); end
   endtask

   initial begin
      test_reset();
      test_divide();
      test_back_to_back();
      test_random(25);
      test_flush_wait();
      test_flush_start();
      test_flush_hold();
      test_backpressure();
      test_reset_midop();
      test_watchdog();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
